// File: rtl/up3_memory.sv
// Processor-side memory for the UP3 core: word RAM, memory-mapped LED/SW/TIMER/CMP/STAT
// registers, and a streaming program loader that takes over the RAM while it runs.
module up3_memory #(
  parameter int RAM_WORDS = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  input  logic        wren,
  output logic [15:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        irq,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        busy
);

  localparam int         AW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [7:0] RAM_LAST = 8'(RAM_WORDS - 1);
  localparam logic [7:0] A_LED    = 8'hF0;
  localparam logic [7:0] A_SW     = 8'hF1;
  localparam logic [7:0] A_TIMER  = 8'hF2;
  localparam logic [7:0] A_CMP    = 8'hF3;
  localparam logic [7:0] A_STAT   = 8'hF4;

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic [15:0] sw_s1_q, sw_s2_q;
  logic [15:0] mem [RAM_WORDS];

  logic loading, cpu_we, ram_hit, ld_beat, stat_clr;

  assign loading = (state_q == S_LOAD);
  assign cpu_we  = wren && !loading;
  assign ram_hit = (addr <= RAM_LAST);
  assign ld_beat = loading && !ld_start && ld_valid;

  // The loader ends on ld_last or after filling the last word; the pointer never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (ld_start) begin
          ptr_d = '0;
        end else if (ld_valid) begin
          ptr_d = ptr_q + 8'd1;
          if (ld_last || ptr_q == RAM_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led_d    = led_q;
    cmp_d    = cmp_q;
    timer_d  = timer_q + 16'd1;
    stat_clr = 1'b0;
    if (cpu_we) begin
      case (addr)
        A_LED:   led_d    = wdata;
        A_TIMER: timer_d  = wdata;
        A_CMP:   cmp_d    = wdata;
        A_STAT:  stat_clr = wdata[0];
        default: ;
      endcase
    end
    // A match in this cycle beats a simultaneous write-1-to-clear.
    flag_d = (timer_q == cmp_q) || (flag_q && !stat_clr);
  end

  // Write-first read mux: registers return their post-write value, TIMER the written word.
  always_comb begin
    rdata_d = '0;
    if (!loading) begin
      if (ram_hit) begin
        rdata_d = cpu_we ? wdata : mem[addr[AW-1:0]];
      end else begin
        case (addr)
          A_LED:   rdata_d = led_d;
          A_SW:    rdata_d = sw_s2_q;
          A_TIMER: rdata_d = cpu_we ? wdata : timer_q;
          A_CMP:   rdata_d = cmp_d;
          A_STAT:  rdata_d = {15'd0, flag_d};
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rdata_q <= '0;
      led_q   <= '0;
      timer_q <= '0;
      cmp_q   <= 16'hFFFF;
      flag_q  <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // RAM is never cleared by reset, and nothing writes it while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_beat)
        mem[ptr_q[AW-1:0]] <= ld_data;
      else if (cpu_we && ram_hit)
        mem[addr[AW-1:0]] <= wdata;
    end
  end

  assign rdata    = rdata_q;
  assign led      = led_q;
  assign irq      = flag_q;
  assign busy     = loading;
  assign ld_ready = loading;

endmodule

// File: tb/tb_up3_memory.sv
// Bench for up3_memory: directed scenarios with literal expectations plus a randomized run
// checked every cycle against an abstract memory-map model; a second 4-word instance covers the loader limit.
module tb_up3_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wren;
  logic [15:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;
  logic        ld_start, ld_valid, ld_last, ld_ready, busy;
  logic [15:0] ld_data;

  logic [7:0]  s_addr;
  logic [15:0] s_rdata, s_led, s_ld_data;
  logic        s_irq, s_ld_start, s_ld_valid, s_ld_last, s_ld_ready, s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  up3_memory #(.RAM_WORDS(240)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wren(wren), .rdata(rdata),
    .sw(sw), .led(led), .irq(irq), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy)
  );

  up3_memory #(.RAM_WORDS(4)) dut_s (
    .clk(clk), .rst(rst), .addr(s_addr), .wdata(16'h0000), .wren(1'b0), .rdata(s_rdata),
    .sw(16'h0000), .led(s_led), .irq(s_irq), .ld_start(s_ld_start), .ld_valid(s_ld_valid),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready), .busy(s_busy)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: memory map as plain arrays, writes applied before the read.
  logic [15:0] m_ram [256];
  logic [15:0] m_rdata, m_led, m_timer, m_cmp, m_s1, m_s2;
  logic        m_flag, m_loading, m_valid = 1'b0;
  int          m_ptr;
  logic        m_match, m_clr, m_tw;
  logic [15:0] m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rdata = 16'h0; m_led = 16'h0; m_timer = 16'h0; m_cmp = 16'hFFFF;
      m_flag = 1'b0; m_s1 = 16'h0; m_s2 = 16'h0; m_loading = 1'b0; m_ptr = 0;
      m_valid = 1'b1;
    end else begin
      m_match = (m_timer == m_cmp);
      m_clr = 1'b0;
      m_tw = 1'b0;
      if (!m_loading && wren) begin
        if (addr < 8'd240) m_ram[addr] = wdata;
        else if (addr == 8'hF0) m_led = wdata;
        else if (addr == 8'hF2) begin m_timer = wdata; m_tw = 1'b1; end
        else if (addr == 8'hF3) m_cmp = wdata;
        else if (addr == 8'hF4) m_clr = wdata[0];
      end
      m_flag = m_match | (m_flag & ~m_clr);
      if (m_loading) m_rd = 16'h0;
      else if (addr < 8'd240) m_rd = m_ram[addr];
      else if (addr == 8'hF0) m_rd = m_led;
      else if (addr == 8'hF1) m_rd = m_s2;
      else if (addr == 8'hF2) m_rd = m_timer;
      else if (addr == 8'hF3) m_rd = m_cmp;
      else if (addr == 8'hF4) m_rd = {15'd0, m_flag};
      else m_rd = 16'h0;
      m_rdata = m_rd;
      if (!m_tw) m_timer = m_timer + 16'd1;
      m_s2 = m_s1;
      m_s1 = sw;
      if (m_loading) begin
        if (ld_start) m_ptr = 0;
        else if (ld_valid) begin
          m_ram[m_ptr] = ld_data;
          if (ld_last || m_ptr == 239) m_loading = 1'b0;
          m_ptr++;
        end
      end else if (ld_start) begin
        m_loading = 1'b1;
        m_ptr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rdata", rdata, m_rdata);
      chk("model_led", led, m_led);
      chk("model_irq", {15'd0, irq}, {15'd0, m_flag});
      chk("model_busy", {15'd0, busy}, {15'd0, m_loading});
      chk("model_ld_ready", {15'd0, ld_ready}, {15'd0, m_loading});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [15:0] d, input logic we);
    addr = a; wdata = d; wren = we;
    step();
    wren = 1'b0;
  endtask

  initial begin
    addr = 8'h00; wdata = 16'h0; wren = 1'b0; sw = 16'h0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 16'h0; ld_last = 1'b0;
    s_addr = 8'h00; s_ld_start = 1'b0; s_ld_valid = 1'b0; s_ld_data = 16'h0; s_ld_last = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_led", led, 16'h0000);
    chk("reset_irq", {15'd0, irq}, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);
    rst = 1'b1;
    step();

    // Loader limit on the 4-word instance: 6 beats, no ld_last.
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0;
    chk("s_busy_start", {15'd0, s_busy}, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      s_ld_valid = 1'b1;
      s_ld_data = 16'hA000 + 16'(i);
      step();
      chk("s_busy_beat", {15'd0, s_busy}, (i < 3) ? 16'h0001 : 16'h0000);
    end
    s_ld_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_addr = 8'(i);
      step();
      chk("s_ram_read", s_rdata, (i < 4) ? (16'hA000 + 16'(i)) : 16'h0000);
    end

    for (int i = 0; i < 240; i++) bus(8'(i), 16'hC000 | 16'(i), 1'b1);

    // RAM access and write-first.
    bus(8'h05, 16'h1234, 1'b1);
    bus(8'h05, 16'h0000, 1'b0);
    chk("ram_read_05", rdata, 16'h1234);
    bus(8'h07, 16'hBEEF, 1'b1);
    chk("ram_write_first_07", rdata, 16'hBEEF);

    // I/O registers.
    sw = 16'hA5A5;
    repeat (3) bus(8'hF1, 16'h0000, 1'b0);
    chk("sw_sync", rdata, 16'hA5A5);
    bus(8'hF0, 16'h00FF, 1'b1);
    chk("led_write", led, 16'h00FF);
    chk("led_write_first", rdata, 16'h00FF);
    bus(8'hF9, 16'h0000, 1'b0);
    chk("unmapped_read", rdata, 16'h0000);
    bus(8'hF1, 16'h1234, 1'b1);
    bus(8'hF1, 16'h0000, 1'b0);
    chk("sw_write_ignored", rdata, 16'hA5A5);

    // Timer match: irq 17 cycles after the TIMER write edge.
    bus(8'hF3, 16'h0010, 1'b1);
    bus(8'hF4, 16'h0001, 1'b1);
    bus(8'hF2, 16'h0000, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("irq_before_match", {15'd0, irq}, 16'h0000);
    end
    step();
    chk("irq_match", {15'd0, irq}, 16'h0001);
    bus(8'hF4, 16'h0001, 1'b1);
    chk("irq_cleared", {15'd0, irq}, 16'h0000);

    // Set wins over a simultaneous clear.
    bus(8'hF3, 16'h0020, 1'b1);
    bus(8'hF2, 16'h0020, 1'b1);
    bus(8'hF4, 16'h0001, 1'b1);
    chk("irq_set_wins", {15'd0, irq}, 16'h0001);
    bus(8'hF4, 16'h0001, 1'b1);
    chk("irq_clear_after", {15'd0, irq}, 16'h0000);

    // Loader: 3 beats with a processor write to 0x10 attempted throughout.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("load_busy", {15'd0, busy}, 16'h0001);
    addr = 8'h10; wdata = 16'h5555; wren = 1'b1;
    ld_valid = 1'b1; ld_data = 16'h0A0B;
    step();
    chk("load_read_zero", rdata, 16'h0000);
    ld_data = 16'h0C0D;
    step();
    chk("load_busy_beat2", {15'd0, busy}, 16'h0001);
    ld_data = 16'h0E0F; ld_last = 1'b1;
    step();
    chk("load_busy_done", {15'd0, busy}, 16'h0000);
    ld_valid = 1'b0; ld_last = 1'b0; wren = 1'b0;
    bus(8'h00, 16'h0, 1'b0); chk("load_ram0", rdata, 16'h0A0B);
    bus(8'h01, 16'h0, 1'b0); chk("load_ram1", rdata, 16'h0C0D);
    bus(8'h02, 16'h0, 1'b0); chk("load_ram2", rdata, 16'h0E0F);
    bus(8'h10, 16'h0, 1'b0); chk("load_cpu_write_blocked", rdata, 16'hC010);

    // Reset mid-load after 2 beats.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h1111;
    step();
    ld_data = 16'h2222;
    step();
    ld_valid = 1'b0;
    chk("pre_reset_busy", {15'd0, busy}, 16'h0001);
    chk("pre_reset_led", led, 16'h00FF);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_busy", {15'd0, busy}, 16'h0000);
    chk("async_reset_led", led, 16'h0000);
    chk("async_reset_ld_ready", {15'd0, ld_ready}, 16'h0000);
    step();
    rst = 1'b1;
    bus(8'h00, 16'h0, 1'b0); chk("reset_kept_ram0", rdata, 16'h1111);
    bus(8'h01, 16'h0, 1'b0); chk("reset_kept_ram1", rdata, 16'h2222);
    bus(8'h02, 16'h0, 1'b0); chk("reset_kept_ram2", rdata, 16'h0E0F);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) addr = 8'($urandom_range(0, 239));
      else if (r < 8) addr = 8'hF0 + 8'($urandom_range(0, 5));
      else addr = 8'($urandom_range(0, 255));
      wdata = 16'($urandom);
      if (addr == 8'hF2 || addr == 8'hF3) wdata = 16'($urandom_range(0, 40));
      wren = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      ld_start = ($urandom_range(0, 39) == 0);
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_data = 16'($urandom);
      ld_last = ($urandom_range(0, 7) == 0);
      step();
    end
    wren = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
